// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: applies a 1-bit shift/rotate step CNT times,
// one step per clock, and returns a registered result and carry with a done pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for START; operands are captured on acceptance
// ST_SHIFT | one step per clock on the working register, count runs down
// ST_DONE  | DONE pulse cycle; S/CO already hold the result
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] F,
    input  logic             CI,
    input  logic [2:0]       HSEL,
    input  logic [CNT_W-1:0] CNT,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] w;
    logic             c;
    logic [2:0]       op;
    logic [CNT_W-1:0] r;

    logic [WIDTH-1:0] w_nxt;
    logic             c_nxt;
    logic             op_uses_carry;
    logic             hsel_uses_carry;

    // One step of the same 1-bit shifter the datapath uses combinationally.
    always_comb begin
        w_nxt = w;
        c_nxt = c;
        case (op)
            3'b000: w_nxt = w;
            3'b001: w_nxt = {w[WIDTH-2:0], 1'b0};
            3'b010: w_nxt = {1'b0, w[WIDTH-1:1]};
            3'b011: w_nxt = '0;
            3'b100: begin
                c_nxt = w[WIDTH-1];
                w_nxt = {w[WIDTH-2:0], c};
            end
            3'b101: w_nxt = {w[WIDTH-2:0], w[WIDTH-1]};
            3'b110: w_nxt = {w[0], w[WIDTH-1:1]};
            3'b111: begin
                c_nxt = w[0];
                w_nxt = {c, w[WIDTH-1:1]};
            end
            default: w_nxt = w;
        endcase
    end

    assign op_uses_carry   = (op == 3'b100) || (op == 3'b111);
    assign hsel_uses_carry = (HSEL == 3'b100) || (HSEL == 3'b111);

    // S/CO are loaded on the edge that enters ST_DONE so they are valid with DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            w     <= '0;
            c     <= 1'b0;
            op    <= 3'b000;
            r     <= '0;
            S     <= '0;
            CO    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        w    <= F;
                        c    <= CI;
                        op   <= HSEL;
                        r    <= CNT;
                        BUSY <= 1'b1;
                        if (CNT == '0) begin
                            state <= ST_DONE;
                            DONE  <= 1'b1;
                            S     <= F;
                            CO    <= hsel_uses_carry ? CI : 1'b0;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    w <= w_nxt;
                    c <= c_nxt;
                    r <= r - CNT_W'(1);
                    if (r == CNT_W'(1)) begin
                        state <= ST_DONE;
                        DONE  <= 1'b1;
                        S     <= w_nxt;
                        CO    <= op_uses_carry ? c_nxt : 1'b0;
                    end
                end
                ST_DONE: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, hand-written
// handshake/reset sequences and randomized operations against an arithmetic model.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             CLK;
    logic             RST;
    logic             START;
    logic [WIDTH-1:0] F;
    logic             CI;
    logic [2:0]       HSEL;
    logic [CNT_W-1:0] CNT;
    logic [WIDTH-1:0] S;
    logic             CO;
    logic             BUSY;
    logic             DONE;

    int checks   = 0;
    int failures = 0;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .F    (F),
        .CI   (CI),
        .HSEL (HSEL),
        .CNT  (CNT),
        .S    (S),
        .CO   (CO),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] f;
        logic       ci;
        logic [2:0] hsel;
        logic [3:0] cnt;
        logic [7:0] exp_s;
        logic       exp_co;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Result of n steps computed as whole-word shifts/rotations; returns {co, s}.
    function automatic logic [8:0] model(input logic [7:0] f, input logic ci,
                                         input logic [2:0] hsel, input int n);
        int v, k, res;
        logic [7:0] s;
        logic co;
        co = 1'b0;
        s  = f;
        case (hsel)
            3'b000: s = f;
            3'b001: s = (n >= 8) ? 8'h00 : 8'((int'(f) << n) & 8'hFF);
            3'b010: s = (n >= 8) ? 8'h00 : 8'(int'(f) >> n);
            3'b011: s = (n == 0) ? f : 8'h00;
            3'b101: begin
                k = n % 8;
                s = 8'(((int'(f) << k) | (int'(f) >> (8 - k))) & 8'hFF);
            end
            3'b110: begin
                k = n % 8;
                s = 8'(((int'(f) >> k) | (int'(f) << (8 - k))) & 8'hFF);
            end
            3'b100: begin
                v   = (int'(ci) << 8) | int'(f);
                k   = n % 9;
                res = ((v << k) | (v >> (9 - k))) & 9'h1FF;
                s   = 8'(res & 8'hFF);
                co  = res[8];
            end
            default: begin
                v   = (int'(ci) << 8) | int'(f);
                k   = n % 9;
                res = ((v >> k) | (v << (9 - k))) & 9'h1FF;
                s   = 8'(res & 8'hFF);
                co  = res[8];
            end
        endcase
        return {co, s};
    endfunction

    // Issue one request, scramble inputs after acceptance, wait for DONE.
    task automatic run_op(input logic [7:0] f, input logic ci, input logic [2:0] hsel,
                          input logic [3:0] cnt, output logic [7:0] s_o, output logic co_o,
                          output int lat, output bit busy_ok, output bit hold_ok);
        logic [7:0] s_prev;
        logic       co_prev;
        int cyc;
        @(negedge CLK);
        s_prev  = S;
        co_prev = CO;
        F = f; CI = ci; HSEL = hsel; CNT = cnt; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        F = 8'($urandom); CI = 1'($urandom); HSEL = 3'($urandom); CNT = 4'($urandom);
        cyc = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!DONE && cyc < 40) begin
            if (!BUSY) busy_ok = 1'b0;
            if (S !== s_prev || CO !== co_prev) hold_ok = 1'b0;
            @(negedge CLK);
            cyc++;
        end
        if (!BUSY) busy_ok = 1'b0;
        lat  = DONE ? cyc : -1;
        s_o  = S;
        co_o = CO;
    endtask

    task automatic do_case(input string name, input logic [7:0] f, input logic ci,
                           input logic [2:0] hsel, input logic [3:0] cnt,
                           input logic [7:0] exp_s, input logic exp_co);
        logic [7:0] s_r;
        logic co_r;
        int lat;
        bit busy_ok, hold_ok;
        run_op(f, ci, hsel, cnt, s_r, co_r, lat, busy_ok, hold_ok);
        check({name, " S"}, int'(s_r), int'(exp_s));
        check({name, " CO"}, int'(co_r), int'(exp_co));
        check({name, " latency"}, lat, int'(cnt) + 1);
        check({name, " busy"}, int'(busy_ok), 1);
        check({name, " hold"}, int'(hold_ok), 1);
        @(negedge CLK);
        check({name, " done_pulse"}, int'({BUSY, DONE}), 0);
        check({name, " S_after"}, int'(S), int'(exp_s));
    endtask

    vec_t vecs[10];

    initial begin
        logic [8:0] m;
        logic [7:0] s_r;
        logic co_r;
        int lat, cyc, ndone, second_done;
        bit busy_ok, hold_ok;

        vecs[0] = '{8'h81, 1'b0, 3'b101, 4'd1, 8'h03, 1'b0};
        vecs[1] = '{8'h81, 1'b0, 3'b100, 4'd2, 8'h05, 1'b0};
        vecs[2] = '{8'h81, 1'b0, 3'b100, 4'd1, 8'h02, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 3'b111, 4'd1, 8'h80, 1'b1};
        vecs[4] = '{8'hA5, 1'b0, 3'b110, 4'd8, 8'hA5, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 3'b001, 4'd9, 8'h00, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 3'b010, 4'd0, 8'h3C, 1'b0};
        vecs[7] = '{8'h81, 1'b1, 3'b100, 4'd0, 8'h81, 1'b1};
        vecs[8] = '{8'h5A, 1'b1, 3'b011, 4'd3, 8'h00, 1'b0};
        vecs[9] = '{8'h6B, 1'b1, 3'b000, 4'd15, 8'h6B, 1'b0};

        RST = 1'b1; START = 1'b1; F = 8'hFF; CI = 1'b1; HSEL = 3'b100; CNT = 4'd3;
        repeat (3) @(negedge CLK);
        check("reset S", int'(S), 0);
        check("reset CO", int'(CO), 0);
        check("reset BUSY", int'(BUSY), 0);
        check("reset DONE", int'(DONE), 0);
        RST = 1'b0; START = 1'b0;

        foreach (vecs[i])
            do_case($sformatf("vec%0d", i), vecs[i].f, vecs[i].ci, vecs[i].hsel,
                    vecs[i].cnt, vecs[i].exp_s, vecs[i].exp_co);

        // START during BUSY is ignored and not queued.
        @(negedge CLK);
        F = 8'h81; CI = 1'b0; HSEL = 3'b101; CNT = 4'd5; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        F = 8'h00; HSEL = 3'b011; CNT = 4'd0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 3;
        while (!DONE && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        m = model(8'h81, 1'b0, 3'b101, 5);
        check("ignored start latency", cyc, 6);
        check("ignored start S", int'(S), int'(m[7:0]));
        ndone = 0;
        repeat (6) begin
            @(negedge CLK);
            if (DONE) ndone++;
        end
        check("ignored start not queued", ndone, 0);
        check("ignored start S kept", int'(S), int'(m[7:0]));

        // Reset in the middle of SHIFT.
        do_case("pre_reset", 8'hC3, 1'b1, 3'b111, 4'd2, 8'hF0, 1'b1);
        @(negedge CLK);
        F = 8'h77; CI = 1'b1; HSEL = 3'b100; CNT = 4'd10; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid reset BUSY", int'(BUSY), 0);
        check("mid reset DONE", int'(DONE), 0);
        check("mid reset S", int'(S), 0);
        check("mid reset CO", int'(CO), 0);
        do_case("post_reset", 8'h81, 1'b0, 3'b101, 4'd1, 8'h03, 1'b0);

        // START held high re-triggers in the first IDLE cycle after DONE.
        @(negedge CLK);
        F = 8'h01; CI = 1'b0; HSEL = 3'b001; CNT = 4'd1; START = 1'b1;
        ndone = 0;
        second_done = -1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge CLK);
            if (DONE) begin
                ndone++;
                if (ndone == 2) second_done = c;
            end
        end
        START = 1'b0;
        check("held start done count", ndone, 4);
        check("held start second done", second_done, 5);
        check("held start S", int'(S), 8'h02);
        repeat (4) @(negedge CLK);

        // Randomized operations against the model.
        for (int t = 0; t < 150; t++) begin
            logic [7:0] f;
            logic ci;
            logic [2:0] hsel;
            logic [3:0] cnt;
            f    = 8'($urandom);
            ci   = 1'($urandom);
            hsel = 3'($urandom_range(7, 0));
            cnt  = 4'($urandom_range(15, 0));
            m = model(f, ci, hsel, int'(cnt));
            run_op(f, ci, hsel, cnt, s_r, co_r, lat, busy_ok, hold_ok);
            check($sformatf("rand%0d S f=%0h h=%0d n=%0d", t, f, hsel, cnt), int'(s_r), int'(m[7:0]));
            check($sformatf("rand%0d CO", t), int'(co_r), int'(m[8]));
            check($sformatf("rand%0d latency", t), lat, int'(cnt) + 1);
            check($sformatf("rand%0d busy", t), int'(busy_ok & hold_ok), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
